dm_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the pipeline MEM stage (port 0) and the debug/DMA bridge (port 1). Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress. One access is issued per cycle; writes commit at the clock edge and read data is returned registered one cycle later. The block sits between the requesters and the data memory, driving its address, write-data, write-enable and store-type inputs.

---
 rtl/dm_arbiter.sv | 148 ++++++++++++++
 tb/tb_dm_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the pipeline MEM
// stage (port 0, fixed priority) and the debug/DMA bridge (port 1). A
// starvation counter forces a port-1 grant after STARVE_MAX consecutive
// waiting cycles, so port 1 always makes forward progress.
//
// Optional feature macro: DM_ARB_ALIGN_CHECK_EN
//   defined   - misaligned stores are consumed without writing; err is sticky
//   undefined - stores pass through unchecked; err is tied 0
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   reqN/weN/addrN/wdataN/stypeN   requester N access (N = 0, 1)
//   gntN                      combinational grant, one-hot or idle
//   rvalidN/rdataN            registered load return, one-cycle strobe
//   err                       sticky misaligned-store flag
//   dm_addr/dm_wdata/dm_we/dm_stype   memory command
//   dm_rdata                  combinational memory read word at dm_addr
module dm_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [2:0]  stype0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [2:0]  stype1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [2:0]  dm_stype,
  input  logic [31:0] dm_rdata
);

  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        force1;
  logic        gnt0_c, gnt1_c;
  logic        we_sel;

  // Grants are gated by reset_n so nothing reaches memory while in reset.
  always_comb begin
    force1 = (wait_cnt_q == STARVE_C) && req1;
    gnt1_c = reset_n && req1 && (!req0 || force1);
    gnt0_c = reset_n && req0 && !gnt1_c;
  end

  // Idle cycles still present port 0's command, with the write enable low.
  always_comb begin
    dm_addr  = gnt1_c ? addr1  : addr0;
    dm_wdata = gnt1_c ? wdata1 : wdata0;
    dm_stype = gnt1_c ? stype1 : stype0;
    we_sel   = 1'b0;
    if (gnt1_c) begin
      we_sel = we1;
    end else if (gnt0_c) begin
      we_sel = we0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req1 || gnt1_c) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < STARVE_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rvalid0_d = gnt0_c && !we0;
    rvalid1_d = gnt1_c && !we1;
    rdata0_d  = rvalid0_d ? dm_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? dm_rdata : rdata1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= 4'd0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 32'd0;
      rdata1_q   <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

`ifdef DM_ARB_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic misaligned;

  // Only sb, sh and sw are legal encodings; anything else counts as misaligned.
  always_comb begin
    unique case (dm_stype)
      3'b000:  misaligned = 1'b0;
      3'b001:  misaligned = dm_addr[0];
      3'b011:  misaligned = (dm_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    dm_we = we_sel && !misaligned;
    err_d = err_q || (we_sel && misaligned);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign dm_we = we_sel;
  assign err   = 1'b0;
`endif

  assign gnt0    = gnt0_c;
  assign gnt1    = gnt1_c;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [2:0]  stype0 = '0, stype1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, dm_we;
  logic [31:0] rdata0, rdata1, dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_stype;

  logic [31:0] mem [0:63];
  assign dm_rdata = mem[dm_addr[7:2]];

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .stype0(stype0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .stype1(stype1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err(err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_stype(dm_stype),
    .dm_rdata(dm_rdata)
  );

  typedef struct {
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [2:0]  stype0, stype1;
    logic        e_gnt0, e_gnt1, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_stype;
    logic        e_rv0;
    logic [31:0] e_rd0;
    logic        e_rv1;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t vecs [0:15];
  int   checks = 0;
  int   errors = 0;

`ifdef DM_ARB_ALIGN_CHECK_EN
  localparam logic MIS_WE  = 1'b0;
  localparam logic MIS_ERR = 1'b1;
`else
  localparam logic MIS_WE  = 1'b1;
  localparam logic MIS_ERR = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0 = v.req0; req1 = v.req1; we0 = v.we0; we1 = v.we1;
    addr0 = v.addr0; addr1 = v.addr1; wdata0 = v.wdata0; wdata1 = v.wdata1;
    stype0 = v.stype0; stype1 = v.stype1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; stype0 = '0; stype1 = '0;
  endtask

  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] M20 = 32'h5A000020;
  localparam logic [31:0] M30 = 32'h5A000030;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h5A000000 | (i << 2);
    mem[4] = CF;

    //           r0 r1 w0 w1 a0     a1     wd0           wd1           s0 s1   g0 g1 we addr   wdata         st   rv0 rd0 rv1 rd1
    vecs[0]  = '{0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h0,        0, 0,   0, 0, 0, 32'h0, 32'h0,        0,   0, 32'h0, 0, 32'h0};
    vecs[1]  = '{1, 0, 0, 0, 32'h10,32'h0, 32'h0,        32'h0,        0, 0,   1, 0, 0, 32'h10,32'h0,        0,   1, CF,    0, 32'h0};
    vecs[2]  = '{0, 1, 0, 1, 32'h0, 32'h22,32'h0,        32'h0000BEEF, 0, 1,   0, 1, 1, 32'h22,32'h0000BEEF, 1,   0, CF,    0, 32'h0};
    vecs[3]  = '{0, 1, 0, 0, 32'h0, 32'h20,32'h0,        32'h0,        0, 0,   0, 1, 0, 32'h20,32'h0,        0,   0, CF,    1, M20};
    vecs[4]  = '{0, 1, 0, 0, 32'h0, 32'h30,32'h0,        32'h0,        0, 0,   0, 1, 0, 32'h30,32'h0,        0,   0, CF,    1, M30};
    vecs[5]  = '{1, 0, 1, 0, 32'h40,32'h0, 32'h11223344, 32'h0,        3, 0,   1, 0, 1, 32'h40,32'h11223344, 3,   0, CF,    0, M30};
    for (int i = 6; i <= 9; i++)
      vecs[i] = '{1, 1, 0, 0, 32'h10,32'h20,32'h0,       32'h0,        0, 0,   1, 0, 0, 32'h10,32'h0,        0,   1, CF,    0, M30};
    vecs[10] = '{1, 1, 0, 0, 32'h10,32'h20,32'h0,        32'h0,        0, 0,   0, 1, 0, 32'h20,32'h0,        0,   0, CF,    1, M20};
    vecs[11] = '{1, 1, 0, 0, 32'h10,32'h20,32'h0,        32'h0,        0, 0,   1, 0, 0, 32'h10,32'h0,        0,   1, CF,    0, M20};
    vecs[12] = '{1, 0, 0, 0, 32'h10,32'h0, 32'h0,        32'h0,        0, 0,   1, 0, 0, 32'h10,32'h0,        0,   1, CF,    0, M20};
    vecs[13] = '{1, 1, 0, 0, 32'h10,32'h30,32'h0,        32'h0,        0, 0,   1, 0, 0, 32'h10,32'h0,        0,   1, CF,    0, M20};
    vecs[14] = '{0, 1, 0, 0, 32'h10,32'h30,32'h0,        32'h0,        0, 0,   0, 1, 0, 32'h30,32'h0,        0,   0, CF,    1, M30};
    vecs[15] = '{0, 0, 0, 0, 32'h0, 32'h0, 32'h0,        32'h0,        0, 0,   0, 0, 0, 32'h0, 32'h0,        0,   0, CF,    0, M30};

    // Reset state
    #2;
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors: one cycle each, wait_cnt carries across rows
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), {31'd0, gnt0}, {31'd0, vecs[i].e_gnt0});
      chk($sformatf("v%0d_gnt1", i), {31'd0, gnt1}, {31'd0, vecs[i].e_gnt1});
      chk($sformatf("v%0d_dm_we", i), {31'd0, dm_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_dm_addr", i), dm_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_dm_wdata", i), dm_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_dm_stype", i), {29'd0, dm_stype}, {29'd0, vecs[i].e_stype});
      @(posedge clk); #1;
      chk($sformatf("v%0d_rvalid0", i), {31'd0, rvalid0}, {31'd0, vecs[i].e_rv0});
      chk($sformatf("v%0d_rdata0", i), rdata0, vecs[i].e_rd0);
      chk($sformatf("v%0d_rvalid1", i), {31'd0, rvalid1}, {31'd0, vecs[i].e_rv1});
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].e_rd1);
    end

    // Reset mid-load: build wait_cnt to 3, reset right after a port-0 load grant
    req0 = 1; addr0 = 32'h10; we0 = 0;
    req1 = 1; addr1 = 32'h20; we1 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("pre_rst_gnt0_%0d", k), {31'd0, gnt0}, 32'd1);
      @(posedge clk);
    end
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("mid_rst_rdata0", rdata0, 32'd0);
    chk("mid_rst_rdata1", rdata1, 32'd0);
    chk("mid_rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("mid_rst_gnt1", {31'd0, gnt1}, 32'd0);
    @(posedge clk); #1;
    chk("in_rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    // wait_cnt restarted from 0: four port-0 grants, then port 1
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("post_rst_gnt0_%0d", k), {31'd0, gnt0}, {31'd0, (k != 4)});
      chk($sformatf("post_rst_gnt1_%0d", k), {31'd0, gnt1}, {31'd0, (k == 4)});
      @(negedge clk);
    end
    #1 idle_inputs();
    @(posedge clk); #1;

    // Misaligned sw to 0x13 from port 0
    req0 = 1; we0 = 1; addr0 = 32'h13; stype0 = 3'b011; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    chk("mis_sw_gnt0", {31'd0, gnt0}, 32'd1);
    chk("mis_sw_dm_we", {31'd0, dm_we}, {31'd0, MIS_WE});
    chk("mis_sw_err_same", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("mis_sw_err_next", {31'd0, err}, {31'd0, MIS_ERR});
    // Aligned sw afterwards writes normally; err stays sticky
    addr0 = 32'h14;
    @(negedge clk);
    chk("al_sw_dm_we", {31'd0, dm_we}, 32'd1);
    @(posedge clk); #1;
    chk("err_sticky", {31'd0, err}, {31'd0, MIS_ERR});
    // Misaligned sh from port 1 while port 0 idles
    idle_inputs();
    req1 = 1; we1 = 1; addr1 = 32'h21; stype1 = 3'b001;
    @(negedge clk);
    chk("mis_sh_gnt1", {31'd0, gnt1}, 32'd1);
    chk("mis_sh_dm_we", {31'd0, dm_we}, {31'd0, MIS_WE});
    @(posedge clk); #1;
    chk("mis_sh_rvalid1", {31'd0, rvalid1}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    chk("err_hold", {31'd0, err}, {31'd0, MIS_ERR});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
